instr_fetch: RTL

//  Fetch unit on the producer side of the 16-bit instruction interface into decoder.

---
 rtl/instr_fetch.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Prefetching instruction fetch unit: req/ack memory side, DEPTH-entry FIFO, valid/ready decoder side.
// Optional macro FETCH_BYPASS_EN presents an acked word in its ack cycle when the FIFO is empty.
module instr_fetch #(
    parameter int            AW       = 16,
    parameter int            DEPTH    = 4,
    parameter logic [AW-1:0] RESET_PC = {AW{1'b0}}
) (
    input  logic          clk,
    input  logic          reset,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [15:0]   mem_rdata,
    output logic [15:0]   instr,
    output logic [AW-1:0] instr_pc,
    output logic          instr_valid,
    input  logic          instr_ready,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] PC_ONE   = {{(AW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        FULL  = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t        state_r;
    logic [AW-1:0] fetch_pc_r;
    logic [CW-1:0] count_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [15:0]   fifo_data_r [DEPTH];
    logic [AW-1:0] fifo_pc_r   [DEPTH];
    logic          mem_req_r;
    logic [AW-1:0] mem_addr_r;
    logic [15:0]   instr_r;
    logic [AW-1:0] instr_pc_r;
    logic          instr_valid_r;

    logic          xfer_s;
    logic          pop_s;
    logic          fetching_s;
    logic          bypass_s;
    logic          push_s;
    logic [AW-1:0] fetch_pc_nx_s;
    logic [CW-1:0] count_nx_s;
    logic [CW-1:0] remain_s;
    logic [PW-1:0] rd_ptr_nx_s;
    logic [15:0]   head_data_s;
    logic [AW-1:0] head_pc_s;

    // Handshake qualifiers, occupancy update and the word that becomes the next FIFO head
    always_comb begin
        xfer_s     = mem_req_r & mem_ack;
        pop_s      = instr_valid_r & instr_ready;
        fetching_s = xfer_s & (state_r == FETCH) & ~redirect;
`ifdef FETCH_BYPASS_EN
        bypass_s   = fetching_s & (count_r == CNT_ZERO);
`else
        bypass_s   = 1'b0;
`endif
        push_s     = fetching_s & ~(bypass_s & instr_ready);
        if (xfer_s && (state_r == FETCH)) begin
            fetch_pc_nx_s = fetch_pc_r + PC_ONE;
        end else begin
            fetch_pc_nx_s = fetch_pc_r;
        end
        case ({push_s, pop_s})
            2'b10:   count_nx_s = count_r + CNT_ONE;
            2'b01:   count_nx_s = count_r - CNT_ONE;
            default: count_nx_s = count_r;
        endcase
        if (pop_s) begin
            remain_s    = count_r - CNT_ONE;
            rd_ptr_nx_s = rd_ptr_r + PTR_ONE;
        end else begin
            remain_s    = count_r;
            rd_ptr_nx_s = rd_ptr_r;
        end
        // When nothing older survives the pop, the incoming word is the new head
        if (remain_s == CNT_ZERO) begin
            head_data_s = mem_rdata;
            head_pc_s   = fetch_pc_r;
        end else begin
            head_data_s = fifo_data_r[rd_ptr_nx_s];
            head_pc_s   = fifo_pc_r[rd_ptr_nx_s];
        end
    end

    // FSM, memory request, FIFO storage/pointers and the registered decoder-side head
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= FETCH;
            fetch_pc_r    <= RESET_PC;
            count_r       <= CNT_ZERO;
            rd_ptr_r      <= {PW{1'b0}};
            wr_ptr_r      <= {PW{1'b0}};
            mem_req_r     <= 1'b0;
            mem_addr_r    <= RESET_PC;
            instr_r       <= 16'h0000;
            instr_pc_r    <= {AW{1'b0}};
            instr_valid_r <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_data_r[i] <= 16'h0000;
                fifo_pc_r[i]   <= {AW{1'b0}};
            end
        end else begin
            if (push_s) begin
                fifo_data_r[wr_ptr_r] <= mem_rdata;
                fifo_pc_r[wr_ptr_r]   <= fetch_pc_r;
            end
            if (redirect) begin
                fetch_pc_r    <= redirect_pc;
                count_r       <= CNT_ZERO;
                rd_ptr_r      <= {PW{1'b0}};
                wr_ptr_r      <= {PW{1'b0}};
                instr_valid_r <= 1'b0;
                // An unacked request must run to completion; its data is thrown away in DROP
                if (mem_req_r && !mem_ack) begin
                    state_r <= DROP;
                end else begin
                    state_r    <= FETCH;
                    mem_req_r  <= 1'b1;
                    mem_addr_r <= redirect_pc;
                end
            end else begin
                fetch_pc_r    <= fetch_pc_nx_s;
                count_r       <= count_nx_s;
                rd_ptr_r      <= rd_ptr_nx_s;
                wr_ptr_r      <= push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
                instr_valid_r <= (count_nx_s != CNT_ZERO);
                if (count_nx_s != CNT_ZERO) begin
                    instr_r    <= head_data_s;
                    instr_pc_r <= head_pc_s;
                end else begin
                    instr_r    <= instr_r;
                    instr_pc_r <= instr_pc_r;
                end
                if (mem_req_r && !mem_ack) begin
                    state_r <= state_r;
                end else if (count_nx_s < DEPTH_C) begin
                    state_r    <= FETCH;
                    mem_req_r  <= 1'b1;
                    mem_addr_r <= fetch_pc_nx_s;
                end else begin
                    state_r   <= FULL;
                    mem_req_r <= 1'b0;
                end
            end
        end
    end

    assign mem_req  = mem_req_r;
    assign mem_addr = mem_addr_r;

`ifdef FETCH_BYPASS_EN
    assign instr       = bypass_s ? mem_rdata  : instr_r;
    assign instr_pc    = bypass_s ? fetch_pc_r : instr_pc_r;
    assign instr_valid = bypass_s | instr_valid_r;
`else
    assign instr       = instr_r;
    assign instr_pc    = instr_pc_r;
    assign instr_valid = instr_valid_r;
`endif

endmodule
